// File: rtl/id_stage_if.sv
// Bundle of everything the decode stage exchanges with its neighbours: the IF handoff,
// the EX handoff, register-file reads and the WB flush requests.
interface id_stage_if #(
  parameter int IF_ID_W = 64,
  parameter int ID_EX_W = 133
);
  logic               if_id_valid;
  logic [IF_ID_W-1:0] if_id_bus;
  logic               id_allowin;
  logic [32:0]        id_if_bus;
  logic               ex_allowin;
  logic               id_ex_valid;
  logic [ID_EX_W-1:0] id_ex_bus;
  logic [4:0]         ex_dest;
  logic [4:0]         mem_dest;
  logic [4:0]         wb_dest;
  logic [4:0]         rf_raddr1;
  logic [4:0]         rf_raddr2;
  logic [31:0]        rf_rdata1;
  logic [31:0]        rf_rdata2;
  logic               wb_ex;
  logic               ertn_flush;

  // The decode stage is the slave; the surrounding pipeline is the master.
  modport slave (
    input  if_id_valid, if_id_bus, ex_allowin, ex_dest, mem_dest, wb_dest,
           rf_rdata1, rf_rdata2, wb_ex, ertn_flush,
    output id_allowin, id_if_bus, id_ex_valid, id_ex_bus, rf_raddr1, rf_raddr2
  );

  modport master (
    output if_id_valid, if_id_bus, ex_allowin, ex_dest, mem_dest, wb_dest,
           rf_rdata1, rf_rdata2, wb_ex, ertn_flush,
    input  id_allowin, id_if_bus, id_ex_valid, id_ex_bus, rf_raddr1, rf_raddr2
  );
endinterface

// File: rtl/id_stage.sv
// LoongArch32 decode stage: latches IF output, reads operands, interlocks on RAW
// hazards (no forwarding), resolves branches and hands the instruction to EX.
module id_stage #(
  parameter int IF_ID_W = 64,
  parameter int ID_EX_W = 133
) (
  input  logic       clk,
  input  logic       resetn,
  id_stage_if.slave  io_pipe
);

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;
  localparam logic [7:0] OP_ST   = 8'h29;

  logic               r_id_valid;
  logic [31:0]        r_pc;
  logic [31:0]        r_inst;

  logic [IF_ID_W-1:0] w_if_id_bus;
  logic [ID_EX_W-1:0] w_id_ex_bus;
  logic [5:0]         w_op;
  logic [4:0]         w_rj;
  logic [4:0]         w_rk;
  logic [4:0]         w_rd;
  logic               w_is_jirl;
  logic               w_is_b;
  logic               w_is_bl;
  logic               w_is_beq;
  logic               w_is_bne;
  logic               w_is_store;
  logic [4:0]         w_raddr2;
  logic [31:0]        w_rj_value;
  logic [31:0]        w_rkd_value;
  logic [4:0]         w_dest;
  logic               w_use1;
  logic               w_use2;
  logic               w_hit1;
  logic               w_hit2;
  logic               w_stall;
  logic               w_ready_go;
  logic               w_flush;
  logic               w_allowin;
  logic [31:0]        w_offs16;
  logic [31:0]        w_offs26;
  logic               w_taken;
  logic [31:0]        w_br_target;
  logic               w_br_taken;

  assign w_if_id_bus = io_pipe.if_id_bus;

  assign w_op       = r_inst[31:26];
  assign w_rj       = r_inst[9:5];
  assign w_rk       = r_inst[14:10];
  assign w_rd       = r_inst[4:0];
  assign w_is_jirl  = (w_op == OP_JIRL);
  assign w_is_b     = (w_op == OP_B);
  assign w_is_bl    = (w_op == OP_BL);
  assign w_is_beq   = (w_op == OP_BEQ);
  assign w_is_bne   = (w_op == OP_BNE);
  assign w_is_store = (r_inst[31:24] == OP_ST);

  // Compare-branches and stores read rd as their second source instead of rk.
  assign w_raddr2    = (w_is_beq | w_is_bne | w_is_store) ? w_rd : w_rk;
  assign w_rj_value  = io_pipe.rf_rdata1;
  assign w_rkd_value = io_pipe.rf_rdata2;

  assign w_dest = w_is_bl ? 5'd1 :
                  (w_is_b | w_is_beq | w_is_bne | w_is_store) ? 5'd0 : w_rd;

  assign w_use1 = ~(w_is_b | w_is_bl);
  assign w_use2 = ~(w_is_b | w_is_bl | w_is_jirl);

  // Without forwarding, any in-flight writer of a used source forces a wait.
  assign w_hit1 = (w_rj != 5'd0) &&
                  ((w_rj == io_pipe.ex_dest) || (w_rj == io_pipe.mem_dest) ||
                   (w_rj == io_pipe.wb_dest));
  assign w_hit2 = (w_raddr2 != 5'd0) &&
                  ((w_raddr2 == io_pipe.ex_dest) || (w_raddr2 == io_pipe.mem_dest) ||
                   (w_raddr2 == io_pipe.wb_dest));
  assign w_stall    = (w_use1 & w_hit1) | (w_use2 & w_hit2);
  assign w_ready_go = ~w_stall;

  assign w_flush   = io_pipe.wb_ex | io_pipe.ertn_flush;
  assign w_allowin = ~r_id_valid | (w_ready_go & io_pipe.ex_allowin);

  assign w_offs16 = {{14{r_inst[25]}}, r_inst[25:10], 2'b00};
  assign w_offs26 = {{4{r_inst[9]}}, r_inst[9:0], r_inst[25:10], 2'b00};

  assign w_taken = (w_is_beq & (w_rj_value == w_rkd_value)) |
                   (w_is_bne & (w_rj_value != w_rkd_value)) |
                   w_is_b | w_is_bl | w_is_jirl;

  assign w_br_target = w_is_jirl           ? (w_rj_value + w_offs16) :
                       (w_is_b | w_is_bl)  ? (r_pc + w_offs26) :
                                             (r_pc + w_offs16);

  assign w_br_taken = r_id_valid & w_taken & w_ready_go & ~w_flush;

  assign w_id_ex_bus = {r_pc, r_inst, w_rj_value, w_rkd_value, w_dest};

  assign io_pipe.id_allowin  = w_allowin;
  assign io_pipe.id_if_bus   = {w_br_taken, w_br_target};
  assign io_pipe.id_ex_valid = r_id_valid & w_ready_go & ~w_flush;
  assign io_pipe.id_ex_bus   = w_id_ex_bus;
  assign io_pipe.rf_raddr1   = w_rj;
  assign io_pipe.rf_raddr2   = w_raddr2;

  // A redirect in flight kills whatever IF hands over in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_id_valid <= 1'b0;
      r_pc       <= 32'd0;
      r_inst     <= 32'd0;
    end else begin
      if (w_flush) begin
        r_id_valid <= 1'b0;
      end else if (w_allowin) begin
        r_id_valid <= io_pipe.if_id_valid & ~w_br_taken;
      end
      if (w_allowin && io_pipe.if_id_valid) begin
        r_pc   <= w_if_id_bus[63:32];
        r_inst <= w_if_id_bus[31:0];
      end
    end
  end

endmodule
